// File: rtl/dmem_pkg.sv
// Shared types and helpers for byte_data_memory: FSM state encoding, byte width,
// access-size and lane-selection helpers.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } dmem_state_e;

    localparam int BYTE_W = 8;

    function automatic int access_bytes(input logic is_byte, input int lanes);
        return is_byte ? 1 : lanes;
    endfunction

    // True when lane j belongs to the first (low) word of an access starting at lane `lane`.
    function automatic logic lane_in_lo(input int j, input int lane, input logic is_byte);
        return is_byte ? (j == lane) : (j >= lane);
    endfunction

endpackage

// File: rtl/byte_data_memory_if.sv
// Request/response bus of byte_data_memory. Handshake: a request transfers on the
// rising clk edge where req_valid && req_ready; rsp_valid is a one-cycle completion pulse.
interface byte_data_memory_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_byte;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bank.sv
// Word-wide synchronous single-port RAM with per-byte-lane write enables.
// Read data is registered (old contents on a simultaneous write); contents are never reset.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic                     i_clk,
    input  logic [DATA_W/BYTE_W-1:0] i_we,
    input  logic [AW-1:0]            i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);
    localparam int NB = DATA_W / BYTE_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        for (int j = 0; j < NB; j++) begin
            if (i_we[j]) r_mem[i_addr][j*BYTE_W +: BYTE_W] <= i_wdata[j*BYTE_W +: BYTE_W];
        end
        r_q <= r_mem[i_addr];
    end

    assign o_rdata = r_q;
endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressable little-endian data memory with word/byte access and range checking.
// Define DMEM_MISALIGN_EN to split misaligned word accesses over two words (LO then HI).
module byte_data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_BYTES = 512
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dm_enable,
    byte_data_memory_if.slave   bus,
    output dmem_state_e         o_dbg_state
);
    localparam int NB          = DATA_W / BYTE_W;
    localparam int LANE_W      = $clog2(NB);
    localparam int DEPTH_WORDS = DEPTH_BYTES / NB;
    localparam int WADDR_W     = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_BYTES);

    dmem_state_e        r_state, w_next;
    logic               r_write, r_byte, r_signed, r_err, r_split;
    logic [LANE_W-1:0]  r_lane;
    logic [WADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0]  r_wdata, r_lo_q;

    logic               w_accept, w_oor, w_mis, w_err, w_split, w_rsp_valid;
    logic [LANE_W-1:0]  w_lane;
    logic [WADDR_W-1:0] w_waddr, w_bank_addr;
    logic [ADDR_W:0]    w_last;
    logic [NB-1:0]      w_we;
    logic [DATA_W-1:0]  w_wr_data, w_ram_q, w_merged, w_rd, w_rdata;

    assign bus.req_ready = rst_n && dm_enable && (r_state == ST_IDLE);
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_lane        = bus.req_addr[LANE_W-1:0];
    assign w_waddr       = bus.req_addr[LANE_W +: WADDR_W];
    // One extra bit so an access running past the top of the address space cannot wrap.
    assign w_last        = {1'b0, bus.req_addr} + (ADDR_W+1)'(access_bytes(bus.req_byte, NB) - 1);
    assign w_oor         = (w_last >= DEPTH_L);
    assign w_mis         = !bus.req_byte && (w_lane != '0);

`ifdef DMEM_MISALIGN_EN
    assign w_split = w_mis && !w_oor;
    assign w_err   = w_oor;
`else
    assign w_split = 1'b0;
    assign w_err   = w_oor || w_mis;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_write  <= 1'b0;
            r_byte   <= 1'b0;
            r_signed <= 1'b0;
            r_err    <= 1'b0;
            r_split  <= 1'b0;
            r_lane   <= '0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_lo_q   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write  <= bus.req_write;
                r_byte   <= bus.req_byte;
                r_signed <= bus.req_signed;
                r_err    <= w_err;
                r_split  <= w_split;
                r_lane   <= w_lane;
                r_waddr  <= w_waddr;
                r_wdata  <= bus.req_wdata;
            end
            if (r_state == ST_LO) r_lo_q <= w_ram_q;
        end
    end

    // Read address is presented in IDLE so the low word is ready in LO; a split read fetches the next word during LO.
    always_comb begin
        w_next      = r_state;
        w_rsp_valid = 1'b0;
        w_bank_addr = w_waddr;
        w_we        = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_LO;
            end
            ST_LO: begin
                w_next      = r_split ? ST_HI : ST_IDLE;
                w_rsp_valid = !r_split;
                w_bank_addr = (r_split && !r_write) ? r_waddr + 1'b1 : r_waddr;
                if (r_write && !r_err) begin
                    for (int j = 0; j < NB; j++) w_we[j] = lane_in_lo(j, int'(r_lane), r_byte);
                end
            end
            ST_HI: begin
                w_next      = ST_IDLE;
                w_rsp_valid = 1'b1;
                w_bank_addr = r_waddr + 1'b1;
                if (r_write) begin
                    for (int j = 0; j < NB; j++) w_we[j] = !lane_in_lo(j, int'(r_lane), 1'b0);
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Write data is rotated so request byte k lands in lane (lane+k) mod NB; reads rotate back.
    always_comb begin
        w_wr_data = '0;
        w_merged  = w_ram_q;
        w_rd      = '0;
        for (int k = 0; k < NB; k++) begin
            w_wr_data[((k + int'(r_lane)) % NB)*BYTE_W +: BYTE_W] = r_wdata[k*BYTE_W +: BYTE_W];
            if ((r_state == ST_HI) && lane_in_lo(k, int'(r_lane), 1'b0))
                w_merged[k*BYTE_W +: BYTE_W] = r_lo_q[k*BYTE_W +: BYTE_W];
        end
        for (int k = 0; k < NB; k++) begin
            w_rd[k*BYTE_W +: BYTE_W] = w_merged[((k + int'(r_lane)) % NB)*BYTE_W +: BYTE_W];
        end
    end

    assign w_rdata = r_byte ? {{(DATA_W-BYTE_W){r_signed & w_rd[BYTE_W-1]}}, w_rd[BYTE_W-1:0]} : w_rd;

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_err   = w_rsp_valid && r_err;
    assign bus.rsp_rdata = (w_rsp_valid && !r_write && !r_err) ? w_rdata : '0;
    assign o_dbg_state   = r_state;

    dmem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH_WORDS),
        .AW     (WADDR_W)
    ) u_bank (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_addr  (w_bank_addr),
        .i_wdata (w_wr_data),
        .o_rdata (w_ram_q)
    );
endmodule

// File: tb/tb_byte_data_memory.sv
// Testbench for byte_data_memory: directed requests feed an expected-response queue
// that a negedge monitor drains; expectations follow DMEM_MISALIGN_EN when defined.
module tb_byte_data_memory;
    import dmem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        dm_enable;
    dmem_state_e dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] exp_q[$];
    logic        exp_err_q[$];
    int          exp_lat_q[$];
    time         exp_t_q[$];
    string       exp_name_q[$];

    byte_data_memory_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    byte_data_memory #(
        .DATA_W      (16),
        .ADDR_W      (16),
        .DEPTH_BYTES (512)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dm_enable   (dm_enable),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required end within 200000 time units");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // driver
    task automatic issue(input string name, input logic wr, input logic bt, input logic sg,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp_rd, input logic exp_err, input int exp_lat);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_ready: got req_ready=0 for 40 cycles, required 1", name);
            return;
        end
        bus.req_write  = wr;
        bus.req_byte   = bt;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        exp_q.push_back(exp_rd);
        exp_err_q.push_back(exp_err);
        exp_lat_q.push_back(exp_lat);
        exp_t_q.push_back($time);
        exp_name_q.push_back(name);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // scoreboard monitor
    string nm;
    time   t0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1, required no response");
                end else begin
                    nm = exp_name_q.pop_front();
                    t0 = exp_t_q.pop_front();
                    check({nm, "_rdata"}, 32'(bus.rsp_rdata), 32'(exp_q.pop_front()));
                    check({nm, "_err"}, 32'(bus.rsp_err), 32'(exp_err_q.pop_front()));
                    check({nm, "_lat"}, 32'(($time - t0) / 10), 32'(exp_lat_q.pop_front()));
                end
            end else begin
                check("idle_rdata", 32'(bus.rsp_rdata), 32'h0);
            end
        end
    end

    initial begin
        int n;
        rst_n          = 1'b0;
        dm_enable      = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_byte   = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check("rst_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_err",   32'(bus.rsp_err),   32'h0);
        check("rst_rdata", 32'(bus.rsp_rdata), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;

        // aligned round trip
        issue("aligned_wr", 1, 0, 0, 16'h0010, 16'hBEEF, 16'h0000, 0, 1);
        issue("aligned_rd", 0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 1);

        // byte write and extension
        issue("pre20_wr",    1, 0, 0, 16'h0020, 16'h1122, 16'h0000, 0, 1);
        issue("byte21_wr",   1, 1, 0, 16'h0021, 16'h3380, 16'h0000, 0, 1);
        issue("byte21_srd",  0, 1, 1, 16'h0021, 16'h0000, 16'hFF80, 0, 1);
        issue("byte21_urd",  0, 1, 0, 16'h0021, 16'h0000, 16'h0080, 0, 1);
        issue("byte20_urd",  0, 1, 0, 16'h0020, 16'h0000, 16'h0022, 0, 1);
        issue("byte20_srd",  0, 1, 1, 16'h0020, 16'h0000, 16'h0022, 0, 1);
        issue("word20_rd",   0, 0, 0, 16'h0020, 16'h0000, 16'h8022, 0, 1);

        // misaligned word access
        issue("pre30_wr", 1, 0, 0, 16'h0030, 16'hA1A0, 16'h0000, 0, 1);
        issue("pre32_wr", 1, 0, 0, 16'h0032, 16'hA3A2, 16'h0000, 0, 1);
`ifdef DMEM_MISALIGN_EN
        issue("mis31_wr",  1, 0, 0, 16'h0031, 16'h1234, 16'h0000, 0, 2);
        issue("mis31_rd",  0, 0, 0, 16'h0031, 16'h0000, 16'h1234, 0, 2);
        issue("b31_rd",    0, 1, 0, 16'h0031, 16'h0000, 16'h0034, 0, 1);
        issue("b32_rd",    0, 1, 0, 16'h0032, 16'h0000, 16'h0012, 0, 1);
        issue("b30_rd",    0, 1, 0, 16'h0030, 16'h0000, 16'h00A0, 0, 1);
        issue("b33_rd",    0, 1, 0, 16'h0033, 16'h0000, 16'h00A3, 0, 1);
`else
        issue("mis31_wr",  1, 0, 0, 16'h0031, 16'h1234, 16'h0000, 1, 1);
        issue("mis31_rd",  0, 0, 0, 16'h0031, 16'h0000, 16'h0000, 1, 1);
        issue("w30_rd",    0, 0, 0, 16'h0030, 16'h0000, 16'hA1A0, 0, 1);
        issue("w32_rd",    0, 0, 0, 16'h0032, 16'h0000, 16'hA3A2, 0, 1);
`endif

        // range boundary, no wrap
        issue("pre00_wr",   1, 0, 0, 16'h0000, 16'hCAFE, 16'h0000, 0, 1);
        issue("oor1ff_wr",  1, 0, 0, 16'h01FF, 16'h9999, 16'h0000, 1, 1);
        issue("oorffff_wr", 1, 0, 0, 16'hFFFF, 16'h7777, 16'h0000, 1, 1);
        issue("w00_rd",     0, 0, 0, 16'h0000, 16'h0000, 16'hCAFE, 0, 1);
        issue("b1ff_wr",    1, 1, 0, 16'h01FF, 16'h005C, 16'h0000, 0, 1);
        issue("b1fe_wr",    1, 1, 0, 16'h01FE, 16'h0011, 16'h0000, 0, 1);
        issue("b1ff_rd",    0, 1, 1, 16'h01FF, 16'h0000, 16'h005C, 0, 1);
        issue("w1fe_rd",    0, 0, 0, 16'h01FE, 16'h0000, 16'h5C11, 0, 1);
        issue("b200_rd",    0, 1, 0, 16'h0200, 16'h0000, 16'h0000, 1, 1);
        issue("w1ff_rd",    0, 0, 0, 16'h01FF, 16'h0000, 16'h0000, 1, 1);

        // dm_enable dropped mid-access: in-flight read completes, nothing new accepted
        issue("pre40_wr", 1, 0, 0, 16'h0040, 16'h0101, 16'h0000, 0, 1);
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("en_ready", 32'(bus.req_ready), 32'h1);
        bus.req_write = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 16'h0010;
        bus.req_valid = 1'b1;
        exp_q.push_back(16'hBEEF);
        exp_err_q.push_back(1'b0);
        exp_lat_q.push_back(1);
        exp_t_q.push_back($time);
        exp_name_q.push_back("en_drop_rd");
        @(posedge clk);
        #1;
        dm_enable     = 1'b0;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h0040;
        bus.req_wdata = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("en_low_ready", 32'(bus.req_ready), 32'h0);
        end
        bus.req_valid = 1'b0;
        dm_enable     = 1'b1;
        issue("w40_rd", 0, 0, 0, 16'h0040, 16'h0000, 16'h0101, 0, 1);

        // reset asserted mid-access
`ifdef DMEM_MISALIGN_EN
        issue("pre50_wr", 1, 0, 0, 16'h0050, 16'h5150, 16'h0000, 0, 1);
        issue("pre52_wr", 1, 0, 0, 16'h0052, 16'h5352, 16'h0000, 0, 1);
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        bus.req_write = 1'b1;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 16'h0051;
        bus.req_wdata = 16'h7766;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        check("mid_lo_state", 32'(dbg_state), 32'(ST_LO));
        @(posedge clk);
        #1;
        check("mid_hi_state", 32'(dbg_state), 32'(ST_HI));
        check("mid_hi_valid", 32'(bus.rsp_valid), 32'h1);
`else
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        bus.req_write = 1'b1;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 16'h0060;
        bus.req_wdata = 16'h2222;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        check("mid_lo_state", 32'(dbg_state), 32'(ST_LO));
        check("mid_lo_valid", 32'(bus.rsp_valid), 32'h1);
`endif
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.rsp_valid), 32'h0);
        check("mid_rst_err",   32'(bus.rsp_err),   32'h0);
        check("mid_rst_rdata", 32'(bus.rsp_rdata), 32'h0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef DMEM_MISALIGN_EN
        issue("rst_b51_rd", 0, 1, 0, 16'h0051, 16'h0000, 16'h0066, 0, 1);
        issue("rst_b52_rd", 0, 1, 0, 16'h0052, 16'h0000, 16'h0052, 0, 1);
        issue("rst_b50_rd", 0, 1, 0, 16'h0050, 16'h0000, 16'h0050, 0, 1);
`endif
        issue("post_rst_rd", 0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 1);

        // drain the scoreboard
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/byte_data_memory.md
BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning word width in bits (multiple of 8, ≥16).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning byte-address width.
REQ-003 SHALL have parameter DEPTH_BYTES, default 512, meaning storage size in bytes (multiple of DATA_W/8).
REQ-004 SHALL have port clk, input, 1, meaning the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port dm_enable, input, 1, meaning the block enable; while low, req_ready=0.
REQ-007 SHALL have port req_valid, input, 1, meaning a request is offered.
REQ-008 SHALL have port req_ready, output, 1, meaning a request can be accepted.
REQ-009 SHALL have port req_write, input, 1, meaning 1=write, 0=read.
REQ-010 SHALL have port req_byte, input, 1, meaning 1=byte access, 0=full-word access.
REQ-011 SHALL have port req_signed, input, 1, meaning a byte read is sign-extended (else zero-extended).
REQ-012 SHALL have port req_addr, input, ADDR_W, meaning the byte address.
REQ-013 SHALL have port req_wdata, input, DATA_W, meaning write data (byte writes use [7:0]).
REQ-014 SHALL have port rsp_valid, output, 1, meaning a one-cycle completion pulse for every accepted request.
REQ-015 SHALL have port rsp_rdata, output, DATA_W, meaning read data, valid with rsp_valid.
REQ-016 SHALL have port rsp_err, output, 1, meaning the access was rejected, valid with rsp_valid.

Function
REQ-017 SHALL accept a request on a rising clk edge where req_valid && req_ready; req_ready=1 only in IDLE with dm_enable=1.
REQ-018 SHALL store data little-endian: byte at address A is in lane A mod (DATA_W/8) of word A/(DATA_W/8).
REQ-019 SHALL use FSM states IDLE, LO, HI: an aligned or byte access goes IDLE->LO->IDLE; a misaligned word access goes IDLE->LO->HI->IDLE.
REQ-020 SHALL assert rsp_valid one cycle after acceptance for aligned/byte accesses and two cycles after acceptance for misaligned word accesses.
REQ-021 SHALL, for a misaligned word access, access the low word in LO and the next word in HI, using per-byte-lane write enables so that untouched bytes are unchanged.
REQ-022 SHALL, for a read, return the assembled bytes in address order; a byte read returns bits [7:0] extended per req_signed.
REQ-023 SHALL flag out-of-range when (req_addr + access bytes - 1) ≥ DEPTH_BYTES: rsp_err=1, rsp_rdata=0, no storage write, single-cycle latency.
REQ-024 SHALL, when a write is flagged out-of-range, perform no partial write and SHALL NOT wrap the address.
REQ-025 SHALL hold rsp_rdata=0 whenever rsp_valid=0 or the completed access was a write.
REQ-026 SHALL, when dm_enable falls mid-access, complete the access in flight and SHALL accept no new request.

Reset
REQ-027 SHALL, while rst_n=0, force the state to IDLE and drive req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-028 SHALL NOT reset storage contents; a reset asserted between LO and HI of a misaligned write leaves the LO bytes written and the HI bytes unchanged.

Configuration
REQ-029 SHALL, with DMEM_MISALIGN_EN defined, split misaligned word accesses per REQ-019 and REQ-021.
REQ-030 SHALL, without DMEM_MISALIGN_EN, complete a misaligned word access in one cycle with rsp_err=1, rsp_rdata=0, no write, and never enter HI.

Structure
REQ-031 SHALL take the FSM state enum and the access-size/lane-mask helper constants from the shared package dmem_pkg.
REQ-032 SHALL instantiate sub-module dmem_bank: a DATA_W-wide, DEPTH_BYTES/(DATA_W/8)-deep synchronous RAM with per-byte-lane write enables.

Verification
REQ-033 SHALL cover an aligned word round trip: write 0xBEEF to address 0x0010, then read 0x0010 -> rsp_rdata=0xBEEF, rsp_err=0, latency 1.
REQ-034 SHALL cover byte extension: write byte 0x80 to 0x0021; a signed byte read -> 0xFF80; an unsigned byte read -> 0x0080; byte 0x0020 is unchanged.
REQ-035 SHALL cover a misaligned access with the macro defined: write 0x1234 to 0x0031 -> bytes 0x31=0x34, 0x32=0x12; read 0x0031 -> 0x1234 at latency 2; 0x0030 and 0x0033 are unchanged.
REQ-036 SHALL cover the misaligned access without the macro: write 0x1234 to 0x0031 -> rsp_err=1, and memory is unchanged.
REQ-037 SHALL cover the boundary: a word write to 0x01FF with DEPTH_BYTES=512 -> rsp_err=1 and address 0x0000 is untouched; a byte write to 0x01FF succeeds.
REQ-038 SHALL cover reset: rst_n pulsed low during HI of a misaligned write -> outputs go 0 immediately, the state returns to IDLE, and the LO bytes persist.
